scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Sequencer for one scan chain built from scan flip-flops with inputs D, CP, TI, TE.
- Per request it serially loads a stimulus word into the chain (TE=1), pulses a single functional capture cycle (TE=0), then shifts the captured response out into a parallel result word.
- Sits between the test/config register block and the chain. It owns the chain's TE and TI pins and observes the chain's last-stage Q.

Parameters:
- DATA_W, 32, maximum chain length in bits and width of the load/unload words.
- LEN_W, 6, width of chain_len. Must satisfy 2**LEN_W > DATA_W.
- FILL, 1'b0, value driven on TI during the shift-out phase.

Ports:
- CP  in  1  clock; all state updates on the rising edge.
- CD  in  1  asynchronous active-low reset (clear).
- start  in  1  request pulse; sampled only in IDLE.
- abort  in  1  synchronous abort; effective in any busy state.
- chain_len  in  LEN_W  number of chain bits N; latched on start.
- load_data  in  DATA_W  stimulus word; latched on start. Bit 0 is shifted first.
- SO  in  1  Q of the last flop in the chain.
- TE  out  1  scan enable to every chain flop; registered.
- TI  out  1  scan data into the first chain flop; registered.
- busy  out  1  high from the first SHIFT_IN cycle through the last SHIFT_OUT cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky flag for an illegal length; cleared by the next accepted start.
- unload_data  out  DATA_W  captured response; valid from done and held until the next accepted start.

Behaviour:
- Reset (CD=0, asynchronous, any state): state=IDLE, TE=0, TI=0, busy=0, done=0, err=0, unload_data=0, counters=0.
  - Reset mid-operation aborts immediately. The chain contents are left as-is.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - TE=0, busy=0.
  - On start=1, latch N=chain_len and load_data, clear err, clear unload_data.
  - If N==0 or N>DATA_W: set err=1, go to DONE, and drive no shift cycles.
  - Otherwise go to SHIFT_IN with bit counter=0.
- Timeline (the edge accepting start is edge 0; cycle k lies between edge k-1 and edge k):
  - Cycles 1..N, SHIFT_IN: TE=1, TI=load_data[k-1]. The chain shifts on each edge.
  - Cycle N+1, CAPTURE: TE=0, TI=0. The chain captures D on edge N+1.
  - Cycles N+2..2N+1, SHIFT_OUT: TE=1, TI=FILL.
    - SO is sampled at the edge ending each cycle.
    - The j-th sample (j=0 first) is written to unload_data[j]. Bits >= N stay 0.
  - Cycle 2N+2, DONE: done=1, busy=0, TE=0, TI=0. Next state is IDLE.
  - Total start-to-done latency: 2N+2 cycles.
- SO values sampled during SHIFT_IN are discarded.
- start while busy or in DONE: ignored. There is no queueing.
- abort=1 in SHIFT_IN, CAPTURE or SHIFT_OUT:
  - Next cycle is IDLE with TE=0, TI=0.
  - No done pulse. err is unchanged. unload_data holds the partial samples.
- abort in IDLE or DONE: no effect (DONE still completes).
- Simultaneous start and abort in IDLE: start wins.
- Bit counter width is LEN_W. It counts 0..N-1 per phase and resets on each phase change. It never wraps past N-1.
- Because TE and TI are registered, the outputs change only on CP edges, with no combinational path from inputs to the chain.

Decomposition:
- Shared package/include holds:
  - state encoding constants (S_IDLE=0, S_SHIFT_IN=1, S_CAPTURE=2, S_SHIFT_OUT=3, S_DONE=4, 3-bit);
  - DATA_W and LEN_W defaults.
- One sub-module: scan_bit_cnt, an LEN_W-bit counter with a clear input and a terminal flag (cnt==N-1), instantiated once and reused for both shift phases.
- The FSM, TI mux and unload shift register live in scan_chain_ctrl.

Test Plan:
- Chain model for all scenarios: 8 chain flops with D=~Q of the same flop, so capture inverts the chain contents.
- N=8, load_data=0xA5, start at edge 0:
  - TE=1 for cycles 1-8, TE=0 in cycle 9, TE=1 for cycles 10-17.
  - done=1 in cycle 18; unload_data=0x5A; err=0.
- N=0 and N=33 (with DATA_W=32): done=1 in cycle 1, err=1, TE never asserted, unload_data=0.
- N=8, abort asserted in cycle 5: TE=0 from cycle 6, busy=0, no done. A fresh start then completes normally with done at cycle 18 after it.
- CD pulsed low in cycle 11 of an N=8 run: TE, TI, busy, done, err and unload_data are all 0 asynchronously and the FSM is in IDLE. A subsequent start works.
- start re-pulsed in cycles 3 and 18 of a run: no effect, done occurs exactly once. A start in the cycle after done is accepted.
- N=1, load_data=0x1, FILL=1, single-flop chain model: TI=1 in cycle 1, capture in cycle 2, shift in cycle 3, done in cycle 4, unload_data=0x0.

Source files
------------

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared definitions for the scan chain sequencer: state encoding and
// default word/length widths.
package scan_chain_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/scan_chain_ctrl_cnt.sv
// Per-phase bit counter: counts 0..len-1, flags the last bit and holds
// there; clear has priority over counting.
module scan_bit_cnt
  import scan_chain_ctrl_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             clr,
  input  logic             en,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] cnt,
  output logic             term
);

  logic [LEN_W-1:0] cnt_r;
  logic             term_s;

  assign term_s = (cnt_r == (len - {{(LEN_W-1){1'b0}}, 1'b1}));
  assign cnt    = cnt_r;
  assign term   = term_s;

  // bit counter state
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (en && !term_s) begin
      cnt_r <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: serial load with TE=1, one functional capture cycle,
// then serial unload of the response into a parallel word.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int   DATA_W = DEF_DATA_W,
  parameter int   LEN_W  = DEF_LEN_W,
  parameter logic FILL   = 1'b0
) (
  input  logic              CP,
  input  logic              CD,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic [DATA_W-1:0] load_data,
  input  logic              SO,
  output logic              TE,
  output logic              TI,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] unload_data
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

  state_t            state_r;
  logic [LEN_W-1:0]  n_r;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] unload_r;
  logic              te_r, ti_r, busy_r, done_r, err_r;
  logic [LEN_W-1:0]  cnt_s;
  logic              term_s, cnt_en_s, cnt_clr_s, len_bad_s;

  assign TE          = te_r;
  assign TI          = ti_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign unload_data = unload_r;

  assign len_bad_s = (chain_len == {LEN_W{1'b0}}) || (chain_len > MAX_LEN);
  assign cnt_en_s  = (state_r == S_SHIFT_IN) || (state_r == S_SHIFT_OUT);
  // Clearing on the terminal bit zeroes the counter for the next phase.
  assign cnt_clr_s = !cnt_en_s || term_s || abort;

  scan_bit_cnt #(.LEN_W(LEN_W)) u_cnt (
    .CP   (CP),
    .CD   (CD),
    .clr  (cnt_clr_s),
    .en   (cnt_en_s),
    .len  (n_r),
    .cnt  (cnt_s),
    .term (term_s)
  );

  // sequencer FSM with registered chain controls and unload register
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_r  <= S_IDLE;
      n_r      <= {LEN_W{1'b0}};
      shreg_r  <= {DATA_W{1'b0}};
      unload_r <= {DATA_W{1'b0}};
      te_r     <= 1'b0;
      ti_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          te_r   <= 1'b0;
          ti_r   <= 1'b0;
          busy_r <= 1'b0;
          if (start) begin
            n_r      <= chain_len;
            err_r    <= len_bad_s;
            unload_r <= {DATA_W{1'b0}};
            if (len_bad_s) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_SHIFT_IN;
              te_r    <= 1'b1;
              ti_r    <= load_data[0];
              shreg_r <= {1'b0, load_data[DATA_W-1:1]};
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SHIFT_IN: begin
          if (abort) begin
            state_r <= S_IDLE;
            te_r    <= 1'b0;
            ti_r    <= 1'b0;
            busy_r  <= 1'b0;
          end else if (term_s) begin
            state_r <= S_CAPTURE;
            te_r    <= 1'b0;
            ti_r    <= 1'b0;
          end else begin
            ti_r    <= shreg_r[0];
            shreg_r <= {1'b0, shreg_r[DATA_W-1:1]};
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            state_r <= S_IDLE;
            te_r    <= 1'b0;
            ti_r    <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= S_SHIFT_OUT;
            te_r    <= 1'b1;
            ti_r    <= FILL;
          end
        end
        S_SHIFT_OUT: begin
          if (abort) begin
            state_r <= S_IDLE;
            te_r    <= 1'b0;
            ti_r    <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            // Each unload bit is written exactly once, so OR-in is enough.
            unload_r <= unload_r | ({{(DATA_W-1){1'b0}}, SO} << cnt_s);
            if (term_s) begin
              state_r <= S_DONE;
              te_r    <= 1'b0;
              ti_r    <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_SHIFT_OUT;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          te_r    <= 1'b0;
          ti_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          te_r    <= 1'b0;
          ti_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl against an 8-flop (or 1-flop) inverting
// chain model; expected unload words flow through a scoreboard queue.
module tb_scan_chain_ctrl;

  logic        CP = 1'b0;
  logic        CD = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  chain_len = 6'd0;
  logic [31:0] load_data = 32'd0;
  logic        SO;
  logic        TE, TI, busy, done, err;
  logic [31:0] unload_data;

  logic [7:0]  chain = 8'h00;
  logic        model_single = 1'b0;
  logic [31:0] sb_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  scan_chain_ctrl #(.DATA_W(32), .LEN_W(6), .FILL(1'b1)) dut (
    .CP          (CP),
    .CD          (CD),
    .start       (start),
    .abort       (abort),
    .chain_len   (chain_len),
    .load_data   (load_data),
    .SO          (SO),
    .TE          (TE),
    .TI          (TI),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .unload_data (unload_data)
  );

  always #5 CP = ~CP;

  // chain model: shift when TE, otherwise capture D = ~Q
  always @(posedge CP) begin
    if (TE) chain <= {chain[6:0], TI};
    else    chain <= ~chain;
  end
  assign SO = model_single ? chain[0] : chain[7];

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request from the start edge through the done cycle, checking every cycle.
  task automatic run_op(input int n, input logic [31:0] data, input logic [31:0] exp_u,
                        input logic exp_e, input int rs_a, input int rs_b);
    bit   legal;
    int   lat;
    logic exp_te, exp_ti, exp_busy;
    legal = (n >= 1) && (n <= 32);
    lat   = legal ? 2 * n + 2 : 1;
    sb_q.push_back(exp_u);
    chain_len = 6'(n);
    load_data = data;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      start = (k == rs_a) || (k == rs_b);
      if (legal) begin
        exp_te = (k <= n) || ((k >= n + 2) && (k <= 2 * n + 1));
        if (k <= n) exp_ti = data[k-1];
        else if ((k >= n + 2) && (k <= 2 * n + 1)) exp_ti = 1'b1;
        else exp_ti = 1'b0;
        exp_busy = (k <= 2 * n + 1);
      end else begin
        exp_te = 1'b0;
        exp_ti = 1'b0;
        exp_busy = 1'b0;
      end
      chk("te", {31'd0, TE}, {31'd0, exp_te});
      chk("ti", {31'd0, TI}, {31'd0, exp_ti});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("done", {31'd0, done}, {31'd0, (k == lat)});
      if (done && sb_q.size() != 0) begin
        chk("err", {31'd0, err}, {31'd0, exp_e});
        chk("unload", unload_data, sb_q.pop_front());
      end
      step();
    end
    start = 1'b0;
    chk("sb_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_te", {31'd0, TE}, 32'd0);
    chk("rst_ti", {31'd0, TI}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_unload", unload_data, 32'd0);
    #4 CD = 1'b1;
    step();
    step();

    // nominal runs, including ignored restarts and back-to-back acceptance
    run_op(8, 32'h0000_00A5, 32'h0000_005A, 1'b0, -1, -1);
    run_op(8, 32'h0000_00A5, 32'h0000_005A, 1'b0, 3, 18);
    run_op(8, 32'h0000_003C, 32'h0000_00C3, 1'b0, -1, -1);

    // illegal lengths
    run_op(0, 32'h0000_00FF, 32'h0000_0000, 1'b1, -1, -1);
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("idle_te", {31'd0, TE}, 32'd0);
    run_op(33, 32'h0000_00FF, 32'h0000_0000, 1'b1, -1, -1);

    // abort in cycle 5
    chain_len = 6'd8;
    load_data = 32'h0000_00FF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int k = 6; k <= 20; k++) begin
      chk("abort_te", {31'd0, TE}, 32'd0);
      chk("abort_ti", {31'd0, TI}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      step();
    end
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_unload", unload_data, 32'd0);
    run_op(8, 32'h0000_0096, 32'h0000_0069, 1'b0, -1, -1);

    // asynchronous reset in cycle 11 of a run
    chain_len = 6'd8;
    load_data = 32'h0000_00A4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("pre_rst_te", {31'd0, TE}, 32'd1);
    chk("pre_rst_unload", unload_data, 32'd1);
    #2 CD = 1'b0;
    #1;
    chk("arst_te", {31'd0, TE}, 32'd0);
    chk("arst_ti", {31'd0, TI}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_unload", unload_data, 32'd0);
    #2 CD = 1'b1;
    step();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    run_op(8, 32'h0000_00A5, 32'h0000_005A, 1'b0, -1, -1);

    // single-flop chain
    model_single = 1'b1;
    run_op(1, 32'h0000_0001, 32'h0000_0000, 1'b0, -1, -1);
    chk("n1_idle_done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
